vec_match_pipe: RTL and testbench
=================================

Name: vec_match_pipe

Overview:
- Parametrised successor to the team's 4-bit arr→out vector block.
- Accepts a WIDTH-bit input vector with a valid/ready handshake.
- Applies a selectable bitwise transform and registers the result (1-cycle latency).
- Also detects matches against a constant PATTERN, keeps a saturating match counter, and flags runs of RUN_LEN consecutive matching beats.
- Sits between a vector producer and a consumer, and is also the standard DUT for the team's pattern benches.

Parameters:
- WIDTH, 4, data vector width (≥1).
- PATTERN, all-ones of WIDTH (4'b1111), match constant.
- RUN_LEN, 3, consecutive matching accepted beats needed to raise run_hit (≥1).
- CNT_W, 8, match_count width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  arr holds a valid vector.
- in_ready  out  1  block can accept this cycle.
- arr  in  WIDTH  input vector.
- mode  in  2  transform select, sampled with the accepted beat.
- clr_count  in  1  synchronous clear of match_count.
- out_valid  out  1  out/match/run_hit valid.
- out_ready  in  1  consumer accepts the output beat.
- out  out  WIDTH  transformed vector.
- match  out  1  accepted arr == PATTERN.
- run_hit  out  1  this beat completes or extends a run of ≥RUN_LEN matches.
- match_count  out  CNT_W  saturating count of matching accepted beats.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out=0, match=0, run_hit=0, match_count=0, FSM=IDLE, run counter=0. Reset mid-transfer discards the held beat. in_ready=1 in the first cycle after reset.
- in_ready = !out_valid || out_ready (combinational; single output register, no bubble under continuous flow).
- Accept when in_valid && in_ready. On the next edge: out_valid=1; out=f(arr,mode); match=(arr==PATTERN); run_hit per FSM.
- Transform modes:
  - 0 pass.
  - 1 bitwise invert.
  - 2 arr & PATTERN.
  - 3 bit reverse (out[i]=arr[WIDTH-1-i]).
- No accept and out_ready=1: out_valid→0, data regs hold.
- No accept and out_ready=0: everything holds. out, match and run_hit must be stable while out_valid && !out_ready.
- match_count:
  - +1 on each accepted matching beat; saturates at 2^CNT_W-1 with no wrap.
  - clr_count has priority: with clr_count=1 the count becomes 0 even if a matching beat is accepted the same cycle.
- Run FSM, advanced only on accepted beats (idle cycles do not break a run). States: IDLE, COUNTING, HIT.
  - IDLE: match → COUNTING with run=1, or → HIT directly if RUN_LEN==1.
  - COUNTING: match → run+1; reaching RUN_LEN → HIT. Mismatch → IDLE, run=0.
  - HIT: match stays in HIT; mismatch → IDLE, run=0.
  - run_hit for a beat = next state is HIT.
  - The run counter saturates at RUN_LEN.
- Out-of-range parameters (WIDTH<1, RUN_LEN<1) are a fatal elaboration check.

Decomposition:
- Package vec_match_pkg: mode enum (MODE_PASS, MODE_INV, MODE_MASK, MODE_REV) and run-FSM state enum (IDLE, COUNTING, HIT).
- One natural sub-module: vec_xform, purely combinational, mode+arr→out, parametrised by WIDTH and PATTERN.
- FSM, counter and handshake stay in vec_match_pipe.

Test Plan (WIDTH=4, PATTERN=4'b1111, RUN_LEN=3, CNT_W=8):
- Modes: arr=4'b0111 sent with mode 0/1/2/3 → out = 0111/1000/0111/1110, each one cycle after accept; match=0 for all.
- Run: accepted beats 1111,1111,1111,1111,0111 with idle gaps between them → run_hit = 0,0,1,1,0; match_count=4.
- Backpressure: accept 1111, hold out_ready=0 for 5 cycles while in_valid=1 with 0001 → in_ready=0, out=1111 stable; on out_ready=1 the 0001 beat is accepted the same cycle and appears the next cycle.
- Counter: 300 matching beats → match_count saturates at 255. Then clr_count=1 together with an accepted 1111 → count=0.
- Reset mid-run: two matches, then rst=1 for 1 cycle, then 1111 → out_valid=0 after reset, run_hit=0, match_count=1.
- Streaming: out_ready=1 and in_valid=1 for 10 cycles → in_ready stays 1 and out_valid stays 1 from cycle 1 on, with no gaps.

Source files
------------

// File: rtl/vec_match_pkg.sv
// Shared types for the vector match pipeline: transform select and run-detector states.
package vec_match_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_MASK = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  // Fixed encodings so older benches that peek at the raw state value keep working.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNTING = 2'd1;
  localparam logic [1:0] ST_HIT      = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    COUNTING = ST_COUNTING,
    HIT      = ST_HIT
  } run_state_e;

endpackage

// File: rtl/vec_xform.sv
// Combinational bitwise transform of one input vector, selected by mode.
module vec_xform
  import vec_match_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = '1
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] arr,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = arr;
    case (mode)
      MODE_PASS: out = arr;
      MODE_INV:  out = ~arr;
      MODE_MASK: out = arr & PATTERN;
      MODE_REV: begin
        for (int i = 0; i < WIDTH; i++) begin
          out[i] = arr[WIDTH-1-i];
        end
      end
      default:   out = arr;
    endcase
  end

endmodule

// File: rtl/vec_match_pipe.sv
// Single-register vector pipeline: transform, pattern match, saturating match count
// and detection of runs of consecutive matching beats.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no matching beats in progress (last accepted beat mismatched)
//   COUNTING | 1..RUN_LEN-1 consecutive matching beats seen
//   HIT      | at least RUN_LEN consecutive matching beats seen
module vec_match_pipe
  import vec_match_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = '1,
  parameter int               RUN_LEN = 3,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] arr,
  input  logic [1:0]       mode,
  input  logic             clr_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             match,
  output logic             run_hit,
  output logic [CNT_W-1:0] match_count
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "vec_match_pipe: WIDTH must be >= 1");
  end
  if (RUN_LEN < 1) begin : g_bad_run_len
    $fatal(1, "vec_match_pipe: RUN_LEN must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "vec_match_pipe: CNT_W must be >= 1");
  end

  localparam int               RUN_W   = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W:0]   RUN_TC  = (RUN_W + 1)'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(RUN_LEN);

  logic             accept;
  logic             arr_match;
  logic [WIDTH-1:0] xf_out;
  run_state_e       state_q;
  run_state_e       state_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W:0]   run_inc;

  // Output register frees up in the same cycle the consumer takes it.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign arr_match = (arr == PATTERN);

  vec_xform #(
    .WIDTH   (WIDTH),
    .PATTERN (PATTERN)
  ) u_xform (
    .mode (mode_e'(mode)),
    .arr  (arr),
    .out  (xf_out)
  );

  // Next run state assuming the current beat is accepted; committed only on accept.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    run_inc = {1'b0, run_q} + (RUN_W + 1)'(1);
    if (!arr_match) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_d   = RUN_W'(1);
          state_d = (RUN_LEN == 1) ? HIT : COUNTING;
        end
        COUNTING: begin
          if (run_inc >= RUN_TC) begin
            state_d = HIT;
            run_d   = RUN_SAT;
          end else begin
            state_d = COUNTING;
            run_d   = run_inc[RUN_W-1:0];
          end
        end
        HIT: begin
          state_d = HIT;
          run_d   = RUN_SAT;
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out         <= '0;
      match       <= 1'b0;
      run_hit     <= 1'b0;
      match_count <= '0;
      state_q     <= IDLE;
      run_q       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out       <= xf_out;
        match     <= arr_match;
        run_hit   <= (state_d == HIT);
        state_q   <= state_d;
        run_q     <= run_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_count) begin
        match_count <= '0;
      end else if (accept && arr_match && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_match_pipe.sv
// Bench for vec_match_pipe: directed scenarios plus random traffic against a
// beat-level reference model.
module tb_vec_match_pipe;

  localparam int         WIDTH   = 4;
  localparam int         RUN_LEN = 3;
  localparam int         CNT_W   = 8;
  localparam logic [3:0] PAT     = 4'b1111;
  localparam int         CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] arr;
  logic [1:0] mode;
  logic       clr_count;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic       match;
  logic       run_hit;
  logic [7:0] match_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state, as seen after the most recent edge
  logic       m_valid;
  logic [3:0] m_out;
  logic       m_match;
  logic       m_hit;
  int         m_cnt;
  int         m_run;
  logic       ir_seen;

  vec_match_pipe #(
    .WIDTH   (WIDTH),
    .PATTERN (PAT),
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .arr         (arr),
    .mode        (mode),
    .clr_count   (clr_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .match       (match),
    .run_hit     (run_hit),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_xf(input logic [3:0] a, input logic [1:0] m);
    logic [3:0] r;
    r = a;
    case (m)
      2'd0: r = a;
      2'd1: r = ~a;
      2'd2: r = a & PAT;
      default: for (int i = 0; i < 4; i++) r[i] = a[3-i];
    endcase
    return r;
  endfunction

  // Called at a negedge: drive one cycle of inputs, check in_ready, advance the
  // model across the next posedge, then check the registered outputs.
  task automatic cycle(input logic r, input logic iv, input logic [3:0] a,
                       input logic [1:0] m, input logic clr, input logic ordy);
    logic acc;
    rst       = r;
    in_valid  = iv;
    arr       = a;
    mode      = m;
    clr_count = clr;
    out_ready = ordy;
    #1;
    ir_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    acc = iv && (!m_valid || ordy);
    if (r) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_match = 1'b0;
      m_hit   = 1'b0;
      m_cnt   = 0;
      m_run   = 0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_out   = ref_xf(a, m);
        m_match = (a == PAT);
        m_run   = m_match ? ((m_run < RUN_LEN) ? m_run + 1 : RUN_LEN) : 0;
        m_hit   = (m_run >= RUN_LEN);
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (clr) m_cnt = 0;
      else if (acc && (a == PAT) && (m_cnt < CNT_MAX)) m_cnt++;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out", 32'(out), 32'(m_out));
    chk("match", 32'(match), 32'(m_match));
    chk("run_hit", 32'(run_hit), 32'(m_hit));
    chk("match_count", 32'(match_count), 32'(m_cnt));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic beat(input logic [3:0] a);
    cycle(1'b0, 1'b1, a, 2'd0, 1'b0, 1'b1);
  endtask

  logic [3:0] mode_exp [4];
  logic       run_exp  [5];
  logic [3:0] run_beats[5];

  initial begin
    mode_exp  = '{4'b0111, 4'b1000, 4'b0111, 4'b1110};
    run_beats = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
    run_exp   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    m_valid = 1'b0; m_out = '0; m_match = 1'b0; m_hit = 1'b0; m_cnt = 0; m_run = 0;
    rst = 1'b1; in_valid = 1'b0; arr = '0; mode = '0; clr_count = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state and in_ready right after reset
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    cycle(1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(ir_seen), 32'd1);

    // transform modes
    for (int m = 0; m < 4; m++) begin
      cycle(1'b0, 1'b1, 4'b0111, 2'(m), 1'b0, 1'b1);
      chk("mode_out", 32'(out), 32'(mode_exp[m]));
      chk("mode_match", 32'(match), 32'd0);
    end

    // run detection with idle gaps
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      beat(run_beats[i]);
      chk("run_hit_seq", 32'(run_hit), 32'(run_exp[i]));
      idle();
      idle();
    end
    chk("run_count", 32'(match_count), 32'd4);

    // backpressure
    beat(4'b1111);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(ir_seen), 32'd0);
      chk("bp_out_hold", 32'(out), 32'hF);
    end
    cycle(1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1);
    chk("bp_release_ready", 32'(ir_seen), 32'd1);
    chk("bp_release_out", 32'(out), 32'h1);

    // counter saturation and clear priority
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) beat(4'b1111);
    chk("cnt_saturate", 32'(match_count), 32'd255);
    cycle(1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, 1'b1);
    chk("cnt_clear", 32'(match_count), 32'd0);

    // reset in the middle of a run
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    beat(4'b1111);
    beat(4'b1111);
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    beat(4'b1111);
    chk("midrst_hit", 32'(run_hit), 32'd0);
    chk("midrst_count", 32'(match_count), 32'd1);

    // continuous streaming
    idle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 4'($urandom), 2'($urandom), 1'b0, 1'b1);
      chk("stream_in_ready", 32'(ir_seen), 32'd1);
      chk("stream_out_valid", 32'(out_valid), 32'd1);
    end

    // random traffic, biased toward the pattern so runs form
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(3) != 0),
            ($urandom_range(1) == 1) ? PAT : 4'($urandom),
            2'($urandom),
            ($urandom_range(15) == 0),
            ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
